// File: rtl/memory.sv
// ----------------------------------------------------------------------------
// memory_pkg / memory
//
// Memory-access stage of the five-stage RV64 pipeline. It sits between the
// E/M pipeline register (dataE) and writeback. It issues loads and stores on
// the data bus, aligns store data and byte strobes into their lanes, and
// extracts and sign- or zero-extends load data. It owns the M/W pipeline
// register, so dataM is registered.
//
// Ports
//   clk            in   pipeline clock
//   reset          in   synchronous, active-high reset
//   dataE          in   execute_data_t from the E/M register
//   dataM          out  memory_data_t, the registered M/W pipeline register
//   dreq_valid     out  data-bus request valid
//   dreq_addr      out  byte address (dataE.result)
//   dreq_size      out  {1'b0, mem_size}
//   dreq_strobe    out  byte-write enables, all zero for loads
//   dreq_data      out  store data shifted into its byte lanes
//   dresp_addr_ok  in   request accepted
//   dresp_data_ok  in   response complete; read data valid for loads
//   dresp_data     in   raw 64-bit read beat
//   stallM         out  upstream must hold dataE stable
//   misalignM      out  pulse while a misaligned access is being dropped
// ----------------------------------------------------------------------------
package memory_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;      // 0=B, 1=H, 2=W, 3=D
        logic       mem_unsigned;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;       // effective address for memory ops
        control_t    ctl;
        logic [4:0]  dst;
        logic        is_bubble;
        logic [63:0] store_data;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] memory_address;
        logic        is_bubble;
    } memory_data_t;

endpackage

module memory
    import memory_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output memory_data_t  dataM,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data,
    output logic          stallM,
    output logic          misalignM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    memory_data_t r_dataM;

    logic         w_memop;
    logic         w_aligned;
    logic         w_access;
    logic [5:0]   w_sh;
    logic [63:0]  w_load_ext;
    memory_data_t w_dataM_next;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic f_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    f_aligned = 1'b1;
            2'd1:    f_aligned = (off[0] == 1'b0);
            2'd2:    f_aligned = (off[1:0] == 2'b00);
            default: f_aligned = (off == 3'b000);
        endcase
    endfunction

    function automatic logic [7:0] f_strobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        f_strobe = base << off;
    endfunction

    // raw is the read beat already shifted down so the access sits in bit 0.
    function automatic logic [63:0] f_extend(input logic [63:0] raw,
                                             input logic [1:0]  size,
                                             input logic        uns);
        case (size)
            2'd0:    f_extend = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    f_extend = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    f_extend = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: f_extend = raw;
        endcase
    endfunction

    function automatic memory_data_t f_bubble();
        memory_data_t b;
        b           = '0;
        b.is_bubble = 1'b1;
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Access decode and lane alignment (combinational from dataE)
    // ------------------------------------------------------------------------
    assign w_memop   = !dataE.is_bubble && (dataE.ctl.mem_read || dataE.ctl.mem_write);
    assign w_aligned = f_aligned(dataE.ctl.mem_size, dataE.result[2:0]);
    assign w_access  = w_memop && w_aligned;
    assign w_sh      = {dataE.result[2:0], 3'b000};

    assign dreq_addr   = dataE.result;
    assign dreq_size   = {1'b0, dataE.ctl.mem_size};
    assign dreq_strobe = dataE.ctl.mem_write ? f_strobe(dataE.ctl.mem_size, dataE.result[2:0]) : 8'h00;
    assign dreq_data   = dataE.store_data << w_sh;

    assign w_load_ext  = f_extend(dresp_data >> w_sh, dataE.ctl.mem_size, dataE.ctl.mem_unsigned);

    // A completed handshake needs data_ok plus either an earlier or a
    // same-cycle address acceptance.
    assign stallM    = w_access && !(dresp_data_ok && (r_state == RESP || dresp_addr_ok));
    // Combinational so the pulse lines up with the instruction that caused it;
    // the pipeline never stalls on it, so it lasts exactly one cycle.
    assign misalignM = w_memop && !w_aligned;

    // ------------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        dreq_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    dreq_valid = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        w_state_next = IDLE;
                    end else if (dresp_addr_ok) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok && dresp_data_ok) begin
                    w_state_next = IDLE;
                end else if (dresp_addr_ok) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (dresp_data_ok) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // M/W pipeline register
    // ------------------------------------------------------------------------
    always_comb begin
        w_dataM_next = f_bubble();
        // Stalled, bubble or dropped misaligned access all leave a bubble.
        if (!stallM && !dataE.is_bubble && !misalignM) begin
            w_dataM_next.pc        = dataE.pc;
            w_dataM_next.ctl       = dataE.ctl;
            w_dataM_next.dst       = dataE.dst;
            w_dataM_next.is_bubble = 1'b0;
            if (dataE.ctl.mem_read) begin
                w_dataM_next.result         = w_load_ext;
                w_dataM_next.memory_address = dataE.result;
            end else if (dataE.ctl.mem_write) begin
                w_dataM_next.result         = dataE.result;
                w_dataM_next.memory_address = dataE.result;
            end else begin
                w_dataM_next.result         = dataE.result;
                w_dataM_next.memory_address = 64'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataM <= f_bubble();
        end else begin
            r_dataM <= w_dataM_next;
        end
    end

    assign dataM = r_dataM;

endmodule

// File: tb/tb_memory.sv
module tb_memory;
    import memory_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    memory_data_t  dataM;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          stallM;
    logic          misalignM;

    int n_cmp  = 0;
    int n_fail = 0;

    memory dut (
        .clk          (clk),
        .reset        (reset),
        .dataE        (dataE),
        .dataM        (dataM),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .stallM       (stallM),
        .misalignM    (misalignM)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        dataE           = '0;
        dataE.is_bubble = 1'b1;
        dresp_addr_ok   = 1'b0;
        dresp_data_ok   = 1'b0;
        dresp_data      = 64'd0;
    endtask

    task automatic drive_mem(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [63:0] addr, input logic [63:0] sd);
        dataE                  = '0;
        dataE.pc               = 64'h8000_0100;
        dataE.result           = addr;
        dataE.dst              = 5'd7;
        dataE.ctl.mem_read     = rd;
        dataE.ctl.mem_write    = wr;
        dataE.ctl.mem_size     = sz;
        dataE.ctl.mem_unsigned = uns;
        dataE.store_data       = sd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_bubble();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (dataM.is_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b want 1", dataM.is_bubble); end
        n_cmp++; if (dataM.pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", dataM.pc); end
        n_cmp++; if (dataM.result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", dataM.result); end
        n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stallM); end
        n_cmp++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dreq_valid); end
        n_cmp++; if (misalignM !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalignM); end
    endtask

    task automatic test_alu();
        dataE        = '0;
        dataE.pc     = 64'h8000_0000;
        dataE.result = 64'h5;
        dataE.dst    = 5'd3;
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stallM); end
        n_cmp++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL alu_valid: got %b want 0", dreq_valid); end
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.pc !== 64'h8000_0000) begin n_fail++; $display("FAIL alu_pc: got %h want 80000000", dataM.pc); end
        n_cmp++; if (dataM.result !== 64'h5) begin n_fail++; $display("FAIL alu_result: got %h want 5", dataM.result); end
        n_cmp++; if (dataM.dst !== 5'd3) begin n_fail++; $display("FAIL alu_dst: got %0d want 3", dataM.dst); end
        n_cmp++; if (dataM.is_bubble !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b want 0", dataM.is_bubble); end
        n_cmp++; if (dataM.memory_address !== 64'd0) begin n_fail++; $display("FAIL alu_maddr: got %h want 0", dataM.memory_address); end
        tick();
    endtask

    task automatic test_lb();
        drive_mem(1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_1003, 64'd0);
        for (int c = 0; c < 5; c++) begin
            dresp_addr_ok = (c == 2);
            dresp_data_ok = 1'b0;
            #1;
            n_cmp++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL lb_stall[%0d]: got %b want 1", c, stallM); end
            n_cmp++; if (dreq_valid !== (c <= 2)) begin n_fail++; $display("FAIL lb_valid[%0d]: got %b want %b", c, dreq_valid, (c <= 2)); end
            n_cmp++; if (dreq_strobe !== 8'h00) begin n_fail++; $display("FAIL lb_strobe[%0d]: got %h want 00", c, dreq_strobe); end
            tick();
            n_cmp++; if (dataM.is_bubble !== 1'b1) begin n_fail++; $display("FAIL lb_mw_bubble[%0d]: got %b want 1", c, dataM.is_bubble); end
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8000_0000;
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL lb_done_stall: got %b want 0", stallM); end
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.result !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_result: got %h want ffffffffffffff80", dataM.result); end
        n_cmp++; if (dataM.memory_address !== 64'h8000_1003) begin n_fail++; $display("FAIL lb_maddr: got %h want 80001003", dataM.memory_address); end
        n_cmp++; if (dataM.is_bubble !== 1'b0) begin n_fail++; $display("FAIL lb_bubble: got %b want 0", dataM.is_bubble); end
        // LBU, zero-wait, same read beat
        drive_mem(1'b1, 1'b0, 2'd0, 1'b1, 64'h8000_1003, 64'd0);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8000_0000;
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.result !== 64'h80) begin n_fail++; $display("FAIL lbu_result: got %h want 80", dataM.result); end
        tick();
    endtask

    task automatic test_sh();
        drive_mem(1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 64'hABCD);
        for (int c = 0; c < 2; c++) begin
            dresp_addr_ok = (c == 1);
            #1;
            n_cmp++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL sh_valid[%0d]: got %b want 1", c, dreq_valid); end
            n_cmp++; if (dreq_data !== 64'hABCD_0000_0000_0000) begin n_fail++; $display("FAIL sh_data[%0d]: got %h want abcd000000000000", c, dreq_data); end
            n_cmp++; if (dreq_strobe !== 8'hC0) begin n_fail++; $display("FAIL sh_strobe[%0d]: got %h want c0", c, dreq_strobe); end
            n_cmp++; if (dreq_size !== 3'd1) begin n_fail++; $display("FAIL sh_size[%0d]: got %0d want 1", c, dreq_size); end
            n_cmp++; if (dreq_addr !== 64'h1006) begin n_fail++; $display("FAIL sh_addr[%0d]: got %h want 1006", c, dreq_addr); end
            n_cmp++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL sh_stall[%0d]: got %b want 1", c, stallM); end
            tick();
        end
        dresp_addr_ok = 1'b0;
        #1;
        n_cmp++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL sh_resp_valid: got %b want 0", dreq_valid); end
        dresp_data_ok = 1'b1;
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.result !== 64'h1006) begin n_fail++; $display("FAIL sh_result: got %h want 1006", dataM.result); end
        n_cmp++; if (dataM.memory_address !== 64'h1006) begin n_fail++; $display("FAIL sh_maddr: got %h want 1006", dataM.memory_address); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats [2];
        beats[0] = 64'h1122_3344_5566_7788;
        beats[1] = 64'hCAFE_F00D_0BAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            drive_mem(1'b1, 1'b0, 2'd3, 1'b0, 64'h2000 + 64'(i * 8), 64'd0);
            dresp_addr_ok = 1'b1;
            dresp_data_ok = 1'b1;
            dresp_data    = beats[i];
            #1;
            n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL ld_stall[%0d]: got %b want 0", i, stallM); end
            n_cmp++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid[%0d]: got %b want 1", i, dreq_valid); end
            tick();
            n_cmp++; if (dataM.result !== beats[i]) begin n_fail++; $display("FAIL ld_result[%0d]: got %h want %h", i, dataM.result, beats[i]); end
        end
        drive_bubble();
        tick();
    endtask

    task automatic test_misalign();
        drive_mem(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0);
        #1;
        n_cmp++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", dreq_valid); end
        n_cmp++; if (misalignM !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalignM); end
        n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", stallM); end
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.is_bubble !== 1'b1) begin n_fail++; $display("FAIL mis_bubble: got %b want 1", dataM.is_bubble); end
        n_cmp++; if (misalignM !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", misalignM); end
        tick();
    endtask

    task automatic test_reset_resp();
        drive_mem(1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'd0);
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        #1;
        n_cmp++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL rr_pre_stall: got %b want 1", stallM); end
        reset = 1'b1;
        drive_bubble();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL rr_stall: got %b want 0", stallM); end
        n_cmp++; if (dataM.is_bubble !== 1'b1) begin n_fail++; $display("FAIL rr_bubble: got %b want 1", dataM.is_bubble); end
        // stray data_ok with nothing presented
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.is_bubble !== 1'b1) begin n_fail++; $display("FAIL rr_late_bubble: got %b want 1", dataM.is_bubble); end
        // a new load must be issued straight from IDLE
        drive_mem(1'b1, 1'b0, 2'd3, 1'b0, 64'h3008, 64'd0);
        #1;
        n_cmp++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rr_idle_valid: got %b want 1", dreq_valid); end
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0123_4567_89AB_CDEF;
        tick();
        drive_bubble();
        #1;
        n_cmp++; if (dataM.result !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL rr_after_result: got %h want 0123456789abcdef", dataM.result); end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive_bubble();
        #1;
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_back_to_back();
        test_misalign();
        test_reset_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
# memory

Memory-access stage of the five-stage RV64 pipeline, sitting between the E/M pipeline register and the writeback stage. It issues loads and stores on the data bus, performs store-data alignment and byte strobes, and extracts and sign- or zero-extends load data. It owns the M/W pipeline register, so `dataM` is a registered output consumed combinationally by writeback. It raises `stallM` to freeze the upstream stages while a bus access is outstanding.

## Interface

- No parameters. XLEN is fixed at 64.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `dataE` in `execute_data_t`: fields used are `pc`, `result` (effective address for memory ops), `ctl`, `dst`, `is_bubble`, and `store_data` (64).
  - `ctl` fields used: `mem_read`, `mem_write`, `mem_size` (2: 0=B, 1=H, 2=W, 3=D), `mem_unsigned`.
- `dataM` out `memory_data_t`: registered; fields `pc`, `result`, `ctl`, `dst`, `memory_address`, `is_bubble`.
- `dreq_valid` out 1: data-bus request valid.
- `dreq_addr` out 64: byte address, equal to `dataE.result`.
- `dreq_size` out 3: `{1'b0, mem_size}`.
- `dreq_strobe` out 8: byte-write enables. All zero for loads.
- `dreq_data` out 64: store data shifted into byte lanes.
- `dresp_addr_ok` in 1: request accepted.
- `dresp_data_ok` in 1: response complete. Carries read data for loads.
- `dresp_data` in 64: raw 64-bit read beat.
- `stallM` out 1: upstream must hold `dataE` stable.
- `misalignM` out 1: single-cycle pulse when a misaligned access is dropped.

## Operation

- An access is a non-bubble `dataE` with `mem_read` or `mem_write` set, and an aligned address.
- Alignment rule: `addr[0]` must be 0 for H; `addr[1:0]` must be 0 for W; `addr[2:0]` must be 0 for D.
- FSM states: IDLE, REQ, RESP.
  - IDLE, access present: drive `dreq_valid=1` combinationally from `dataE`. If `addr_ok`, go to RESP, else go to REQ.
  - REQ: hold `dreq_valid=1` with unchanged fields. Go to RESP on `addr_ok`.
  - RESP: `dreq_valid=0`. On `data_ok`, go to IDLE.
  - `data_ok` arriving in the same cycle as `addr_ok` completes the access. The FSM returns directly to IDLE.
- `stallM` = access present AND NOT (`data_ok` this cycle AND (state==RESP OR `addr_ok` this cycle)).
- Lane shift: `sh = addr[2:0]*8`.
- Store data: `dreq_data = store_data << sh`.
- Store strobe: `0x01`, `0x03`, `0x0F` or `0xFF` for B, H, W, D, then shifted left by `addr[2:0]`.
- Load extract: `raw = dresp_data >> sh`, then truncate to the access size. Sign-extend when `mem_unsigned=0`, zero-extend when `mem_unsigned=1`.
- M/W register update, every cycle:
  - While `stallM=1`: load a bubble (`is_bubble=1`, all other fields 0).
  - Non-stalled load: copy `dataE` fields; `result` = extended load data; `memory_address` = address.
  - Non-stalled store: copy fields; `result` = `dataE.result`; `memory_address` = address.
  - Non-memory instruction: copy all fields; `memory_address=0`.
  - Bubble input: produce a bubble.
- Misaligned access:
  - No request is issued and no stall occurs.
  - `misalignM` pulses for 1 cycle.
  - The instruction passes as a bubble, so writeback does not hand it in.

## Timing

- Reset (synchronous, takes effect at the next edge):
  - State = IDLE.
  - `dataM` = bubble (`is_bubble=1`, others 0).
  - `dreq_valid`, `stallM` and `misalignM` = 0 for the cycle after the edge, unless `dataE` presents an access.
- Reset mid-access:
  - Abandons the access and returns to IDLE.
  - A `data_ok` arriving while in IDLE with no access present is ignored.
- Latency:
  - Non-memory instruction: `dataE` → `dataM` in 1 cycle.
  - Access: 1 cycle after the `data_ok` cycle.
  - Best case, `addr_ok` and `data_ok` in the same cycle as valid: 1 cycle, no stall.
- While `dreq_valid=1` and `addr_ok=0`, `addr`, `size`, `strobe` and `data` must not change.
- Back-to-back accesses: IDLE after `data_ok` allows the next request in the very next cycle.

## Test plan

- **ALU op, no memory:** `pc=0x80000000`, `result=0x5`, `dst=3` → next cycle `dataM` has the same values, `is_bubble=0`, `memory_address=0`, `stallM` never high.
- **Byte load (LB):**
  - Stimulus: `addr=0x80001003`, `mem_unsigned=0`; `addr_ok` after 2 cycles, `data_ok` 3 cycles later, `dresp_data=0x00000000_80000000`.
  - Response: `strobe=0x00`, `stallM` high for 5 cycles, then `dataM.result=0xFFFFFFFF_FFFFFF80`.
  - Variant, LBU with the same data: `result=0x80`.
- **Halfword store (SH):** `addr=0x1006`, `store_data=0xABCD` → `dreq_data=0xABCD0000_00000000`, `strobe=0xC0`, `size=1`, valid held until `addr_ok`.
- **Zero-wait doubleword load (LD):** `addr_ok` and `data_ok` both in the first cycle, `dresp_data=0x1122334455667788` → no stall; next cycle `dataM.result=0x1122334455667788`.
- **Misaligned word load (LW):** `addr=0x1002` → `dreq_valid` stays 0, `misalignM` pulses 1 cycle, `dataM.is_bubble=1`.
- **Reset during RESP:** assert `reset` for 1 cycle → state IDLE, `dataM.is_bubble=1`, `stallM=0`; a late `data_ok` with no access present has no effect.
